pll_lock_seq: RTL and testbench

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

---
 rtl/pll_lock_seq_pkg.sv | 26 ++
 rtl/pll_lock_seq_if.sv | 25 ++
 rtl/pll_lock_seq_freq_meas.sv | 41 ++++
 rtl/pll_lock_seq.sv | 140 ++++++++++++++
 tb/tb_pll_lock_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_lock_seq_pkg.sv
// rtl/pll_lock_seq_pkg.sv - shared types, default parameters and helpers for the PLL lock sequencer
package pll_pkg;

   typedef enum logic [1:0] {
      PLL_RESET    = 2'd0,
      FREQ_SEARCH  = 2'd1,
      FREQ_LOCKED  = 2'd2,
      PHASE_LOCKED = 2'd3
   } lock_state_t;

   localparam int         WIN_DEF        = 32;
   localparam int         FTOL_DEF       = 1;
   localparam int         PH_TOL_DEF     = 4;
   localparam int         LOCK_CNT_DEF   = 16;
   localparam int         UNLOCK_CNT_DEF = 4;
   localparam int         RST_CYCLES_DEF = 8;
   localparam logic [7:0] FCODE_INIT_DEF = 8'd128;

   // Nine bits wide so that -128 maps to +128 instead of wrapping.
   function automatic logic [8:0] abs9(input logic [7:0] v);
      logic [8:0] w;
      w = {v[7], v};
      return w[8] ? (~w + 9'd1) : w;
   endfunction

endpackage

// File: rtl/pll_lock_seq_if.sv
// rtl/pll_lock_seq_if.sv - control/status bundle between the sequencer and its environment
interface pll_lock_seq_if;
   import pll_pkg::*;

   logic              enable;
   logic              fb_pulse;
   logic signed [7:0] phase_err;
   logic              brake;
   logic              pll_resetn;
   logic [7:0]        dco_fcode;
   logic              loop_en;
   lock_state_t       lock_state;
   logic              search_fail;

   modport master (
      output enable, fb_pulse, phase_err, brake,
      input  pll_resetn, dco_fcode, loop_en, lock_state, search_fail
   );

   modport slave (
      input  enable, fb_pulse, phase_err, brake,
      output pll_resetn, dco_fcode, loop_en, lock_state, search_fail
   );

endinterface

// File: rtl/pll_lock_seq_freq_meas.sv
// rtl/pll_lock_seq_freq_meas.sv - back-to-back WIN-cycle windows counting feedback pulses
module freq_meas #(
   parameter int WIN = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       fb_pulse_i,
   output logic       done,
   output logic [6:0] count
);
   localparam int            WW       = (WIN > 1) ? $clog2(WIN) : 1;
   localparam logic [WW-1:0] WIN_LAST = WW'(WIN - 1);

   logic [WW-1:0] win_q, win_d;
   logic [6:0]    fb_q, fb_d;

   // count already includes the last cycle's pulse so the verdict lands on the window's final edge
   assign done  = (win_q == WIN_LAST);
   assign count = (fb_pulse_i && (fb_q != 7'd127)) ? fb_q + 7'd1 : fb_q;

   always_comb begin
      win_d = win_q + WW'(1);
      fb_d  = count;
      if (clr_i || done) begin
         win_d = '0;
         fb_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_q <= '0;
         fb_q  <= '0;
      end else begin
         win_q <= win_d;
         fb_q  <= fb_d;
      end
   end

endmodule

// File: rtl/pll_lock_seq.sv
// rtl/pll_lock_seq.sv - PLL bring-up sequencer: core reset, coarse DCO search, phase lock tracking
module pll_lock_seq
   import pll_pkg::*;
#(
   parameter int         WIN        = WIN_DEF,
   parameter int         FTOL       = FTOL_DEF,
   parameter int         PH_TOL     = PH_TOL_DEF,
   parameter int         LOCK_CNT   = LOCK_CNT_DEF,
   parameter int         UNLOCK_CNT = UNLOCK_CNT_DEF,
   parameter int         RST_CYCLES = RST_CYCLES_DEF,
   parameter logic [7:0] FCODE_INIT = FCODE_INIT_DEF
) (
   input logic           refclk,
   input logic           reset,
   pll_lock_seq_if.slave bus
);
   lock_state_t state_q, state_d;
   logic [15:0] rst_cnt_q, rst_cnt_d;
   logic [15:0] run_q, run_d;
   logic        good_q, good_d;
   logic [7:0]  fcode_q, fcode_d;
   logic        fail_q, fail_d;

   logic        win_done;
   logic [6:0]  win_count;
   logic        in_phase;

   freq_meas #(.WIN(WIN)) u_freq_meas (
      .clk        (refclk),
      .rst        (reset),
      .clr_i      (state_q != FREQ_SEARCH),
      .fb_pulse_i (bus.fb_pulse),
      .done       (win_done),
      .count      (win_count)
   );

   assign in_phase = int'(abs9(bus.phase_err)) <= PH_TOL;

   // run_q counts in-phase cycles in FREQ_LOCKED and out-of-phase cycles in PHASE_LOCKED
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      run_d     = run_q;
      good_d    = good_q;
      fcode_d   = fcode_q;
      fail_d    = fail_q;
      if (!bus.enable) begin
         state_d   = PLL_RESET;
         rst_cnt_d = '0;
         run_d     = '0;
         good_d    = 1'b0;
         fcode_d   = FCODE_INIT;
         fail_d    = 1'b0;
      end else begin
         unique case (state_q)
            PLL_RESET: begin
               if (int'(rst_cnt_q) >= RST_CYCLES - 1) begin
                  state_d   = FREQ_SEARCH;
                  rst_cnt_d = '0;
               end else begin
                  rst_cnt_d = rst_cnt_q + 16'd1;
               end
            end
            FREQ_SEARCH: begin
               if (win_done) begin
                  if (int'(win_count) < WIN - FTOL) begin
                     good_d = 1'b0;
                     if (fcode_q == 8'hFF) fail_d = 1'b1;
                     else                  fcode_d = fcode_q + 8'd1;
                  end else if (int'(win_count) > WIN + FTOL) begin
                     good_d = 1'b0;
                     if (fcode_q == 8'h00) fail_d = 1'b1;
                     else                  fcode_d = fcode_q - 8'd1;
                  end else if (good_q) begin
                     state_d = FREQ_LOCKED;
                     good_d  = 1'b0;
                     run_d   = '0;
                  end else begin
                     good_d = 1'b1;
                  end
               end
            end
            FREQ_LOCKED: begin
               if (bus.brake) begin
                  state_d = FREQ_SEARCH;
                  run_d   = '0;
                  good_d  = 1'b0;
               end else if (!in_phase) begin
                  run_d = '0;
               end else if (int'(run_q) >= LOCK_CNT - 1) begin
                  state_d = PHASE_LOCKED;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 16'd1;
               end
            end
            PHASE_LOCKED: begin
               if (bus.brake) begin
                  state_d = FREQ_SEARCH;
                  run_d   = '0;
                  good_d  = 1'b0;
               end else if (in_phase) begin
                  run_d = '0;
               end else if (int'(run_q) >= UNLOCK_CNT - 1) begin
                  state_d = FREQ_LOCKED;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 16'd1;
               end
            end
            default: state_d = PLL_RESET;
         endcase
      end
   end

   always_ff @(posedge refclk) begin
      if (reset) begin
         state_q   <= PLL_RESET;
         rst_cnt_q <= '0;
         run_q     <= '0;
         good_q    <= 1'b0;
         fcode_q   <= FCODE_INIT;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         run_q     <= run_d;
         good_q    <= good_d;
         fcode_q   <= fcode_d;
         fail_q    <= fail_d;
      end
   end

   assign bus.lock_state  = state_q;
   assign bus.pll_resetn  = (state_q != PLL_RESET);
   assign bus.loop_en     = (state_q == FREQ_LOCKED) || (state_q == PHASE_LOCKED);
   assign bus.dco_fcode   = fcode_q;
   assign bus.search_fail = fail_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb/tb_pll_lock_seq.sv - scoreboard bench for pll_lock_seq with a behavioural reference model
module tb_pll_lock_seq;
   import pll_pkg::*;

   localparam int WIN = 32, FTOL = 1, PH_TOL = 4, LOCK_CNT = 16, UNLOCK_CNT = 4;
   localparam int RST_CYCLES = 8, FCODE_INIT = 128;

   typedef struct {
      int          cyc;
      lock_state_t st;
      bit          rn;
      int          fc;
      bit          le;
      bit          sf;
   } exp_t;

   logic clk;
   logic rst;
   pll_lock_seq_if bus ();

   pll_lock_seq dut (
      .refclk (clk),
      .reset  (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_steps  = 0;
   exp_t exp_q[$];

   lock_state_t m_state;
   int          m_rc, m_good, m_run, m_fcode;
   bit          m_fail;
   bit          m_win[$];

   task automatic model_clear();
      m_state = PLL_RESET;
      m_rc    = 0;
      m_good  = 0;
      m_run   = 0;
      m_fcode = FCODE_INIT;
      m_fail  = 0;
      m_win.delete();
   endtask

   task automatic model_step(bit r, bit en, bit fb, int pe, bit brk);
      int cnt, mag;
      mag = (pe < 0) ? -pe : pe;
      if (r || !en) begin
         model_clear();
         return;
      end
      case (m_state)
         PLL_RESET: begin
            m_rc++;
            if (m_rc == RST_CYCLES) begin
               m_rc = 0;
               m_state = FREQ_SEARCH;
               m_win.delete();
               m_good = 0;
            end
         end
         FREQ_SEARCH: begin
            m_win.push_back(fb);
            if (m_win.size() == WIN) begin
               cnt = 0;
               foreach (m_win[i]) cnt += int'(m_win[i]);
               if (cnt > 127) cnt = 127;
               if (cnt < WIN - FTOL) begin
                  m_good = 0;
                  if (m_fcode == 255) m_fail = 1; else m_fcode++;
               end else if (cnt > WIN + FTOL) begin
                  m_good = 0;
                  if (m_fcode == 0) m_fail = 1; else m_fcode--;
               end else begin
                  m_good++;
                  if (m_good == 2) begin
                     m_state = FREQ_LOCKED;
                     m_good = 0;
                     m_run = 0;
                  end
               end
               m_win.delete();
            end
         end
         default: begin
            if (brk) begin
               m_state = FREQ_SEARCH;
               m_run = 0;
               m_good = 0;
               m_win.delete();
            end else if (m_state == FREQ_LOCKED) begin
               m_run = (mag <= PH_TOL) ? m_run + 1 : 0;
               if (m_run == LOCK_CNT) begin
                  m_state = PHASE_LOCKED;
                  m_run = 0;
               end
            end else begin
               m_run = (mag > PH_TOL) ? m_run + 1 : 0;
               if (m_run == UNLOCK_CNT) begin
                  m_state = FREQ_LOCKED;
                  m_run = 0;
               end
            end
         end
      endcase
   endtask

   task automatic step(bit r, bit en, bit fb, int pe, bit brk);
      exp_t e;
      @(negedge clk);
      rst           = r;
      bus.enable    = en;
      bus.fb_pulse  = fb;
      bus.phase_err = 8'(pe);
      bus.brake     = brk;
      model_step(r, en, fb, pe, brk);
      n_steps++;
      e.cyc = n_steps;
      e.st  = m_state;
      e.rn  = (m_state != PLL_RESET);
      e.fc  = m_fcode;
      e.le  = (m_state == FREQ_LOCKED) || (m_state == PHASE_LOCKED);
      e.sf  = m_fail;
      exp_q.push_back(e);
   endtask

   task automatic run(int n, bit en, bit fb, int pe, bit brk);
      for (int i = 0; i < n; i++) step(1'b0, en, fb, pe, brk);
   endtask

   // Directed spot check from hand-derived constants; call exactly once after a step.
   task automatic chk(string name, lock_state_t st, int fc, bit sf);
      bit rn, le;
      @(posedge clk);
      #2;
      rn = (st != PLL_RESET);
      le = (st == FREQ_LOCKED) || (st == PHASE_LOCKED);
      n_checks++;
      if (bus.lock_state !== st || int'(bus.dco_fcode) != fc || bus.search_fail !== sf ||
          bus.pll_resetn !== rn || bus.loop_en !== le) begin
         n_fail++;
         $display("FAIL %s: state=%0d fcode=%0d fail=%0b rstn=%0b loop=%0b, expected state=%0d fcode=%0d fail=%0b rstn=%0b loop=%0b",
                  name, bus.lock_state, bus.dco_fcode, bus.search_fail, bus.pll_resetn, bus.loop_en,
                  st, fc, sf, rn, le);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.lock_state !== e.st || bus.pll_resetn !== e.rn || int'(bus.dco_fcode) != e.fc ||
                bus.loop_en !== e.le || bus.search_fail !== e.sf) begin
               n_fail++;
               $display("FAIL cycle %0d: state=%0d rstn=%0b fcode=%0d loop=%0b fail=%0b, expected state=%0d rstn=%0b fcode=%0d loop=%0b fail=%0b",
                        e.cyc, bus.lock_state, bus.pll_resetn, bus.dco_fcode, bus.loop_en, bus.search_fail,
                        e.st, e.rn, e.fc, e.le, e.sf);
            end
         end
      end
   end

   initial begin : stimulus
      int dens, pmode, pe;
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.fb_pulse = 1'b0;
      bus.phase_err = '0;
      bus.brake = 1'b0;
      model_clear();

      step(1, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      chk("reset_state", PLL_RESET, 128, 0);

      // clean feedback: search, freq lock after two windows, phase lock after 16 cycles
      run(7, 1, 1, 0, 0);   chk("rst_hold", PLL_RESET, 128, 0);
      run(1, 1, 1, 0, 0);   chk("search_entry", FREQ_SEARCH, 128, 0);
      run(63, 1, 1, 0, 0);  chk("search_before_lock", FREQ_SEARCH, 128, 0);
      run(1, 1, 1, 0, 0);   chk("freq_locked", FREQ_LOCKED, 128, 0);
      run(15, 1, 1, 0, 0);  chk("before_phase_lock", FREQ_LOCKED, 128, 0);
      run(1, 1, 1, 0, 0);   chk("phase_locked", PHASE_LOCKED, 128, 0);

      // short phase excursion tolerated; four cycles of -128 drop phase lock
      run(3, 1, 1, 5, 0);
      run(2, 1, 1, 0, 0);    chk("glitch_kept", PHASE_LOCKED, 128, 0);
      run(3, 1, 1, -128, 0); chk("three_out", PHASE_LOCKED, 128, 0);
      run(1, 1, 1, -128, 0); chk("unlock", FREQ_LOCKED, 128, 0);
      run(16, 1, 1, 0, 0);   chk("relock", PHASE_LOCKED, 128, 0);

      // brake pulse, then recovery
      run(1, 1, 1, 0, 1);    chk("brake", FREQ_SEARCH, 128, 0);
      run(64, 1, 1, 0, 0);   chk("brake_relock", FREQ_LOCKED, 128, 0);
      run(16, 1, 1, 0, 0);   chk("brake_phase", PHASE_LOCKED, 128, 0);
      run(1, 0, 1, 0, 1);    chk("disable_over_brake", PLL_RESET, 128, 0);

      // 28 of 32 pulses for three windows -> three upward steps, then lock at 131
      run(8, 1, 1, 0, 0);
      for (int w = 0; w < 3; w++)
         for (int i = 0; i < 32; i++) step(0, 1, (i < 28), 0, 0);
      chk("slow_steps", FREQ_SEARCH, 131, 0);
      run(63, 1, 1, 0, 0);   chk("slow_pre_lock", FREQ_SEARCH, 131, 0);
      run(1, 1, 1, 0, 0);    chk("slow_lock", FREQ_LOCKED, 131, 0);

      // no feedback at all: code climbs to 255, then search_fail
      run(1, 0, 0, 0, 0);
      run(8 + 127 * 32, 1, 0, 0, 0); chk("fcode_top", FREQ_SEARCH, 255, 0);
      run(32, 1, 0, 0, 0);   chk("search_fail", FREQ_SEARCH, 255, 1);
      run(1, 0, 0, 0, 0);    chk("fail_cleared", PLL_RESET, 128, 0);

      // reset in the middle of a lock
      run(8 + 64 + 5, 1, 1, 0, 0);
      step(1, 1, 1, 0, 1);   chk("reset_mid_lock", PLL_RESET, 128, 0);

      dens = 100;
      pmode = 0;
      for (int c = 0; c < 3000; c++) begin
         bit r, en, fb, brk;
         if (c % 64 == 0) begin
            case ($urandom_range(0, 3))
               0: dens = 100;
               1: dens = 97;
               2: dens = 88;
               default: dens = 0;
            endcase
            pmode = $urandom_range(0, 2);
         end
         r   = ($urandom_range(0, 499) == 0);
         en  = ($urandom_range(0, 299) != 0);
         brk = ($urandom_range(0, 149) == 0);
         fb  = ($urandom_range(0, 99) < dens);
         case (pmode)
            0: pe = int'($urandom_range(0, 8)) - 4;
            1: pe = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) - 128
                                                : int'($urandom_range(0, 12)) - 6;
            default: pe = ($urandom_range(0, 39) == 0) ? -128 : int'($urandom_range(0, 10)) - 5;
         endcase
         step(r, en, fb, pe, brk);
      end

      repeat (3) @(posedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
